// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ps2_pkg
// Brief    : Shared types and constants for the PS/2 Set-2 scan-code decoder:
//            decode state enum, scan-code and ASCII constants, register map.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Prefix-tracking states of the scan-code decoder
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    // Prefix bytes
    localparam logic [7:0] C_SC_E0        = 8'hE0;
    localparam logic [7:0] C_SC_F0        = 8'hF0;

    // Keyboard protocol bytes that never belong to a key sequence
    localparam logic [7:0] C_SC_BAT_OK    = 8'hAA;
    localparam logic [7:0] C_SC_ACK       = 8'hFA;
    localparam logic [7:0] C_SC_ECHO      = 8'hEE;
    localparam logic [7:0] C_SC_RESEND    = 8'hFE;
    localparam logic [7:0] C_SC_OVERRUN   = 8'h00;

    // Modifier keys
    localparam logic [7:0] C_SC_LSHIFT    = 8'h12;
    localparam logic [7:0] C_SC_RSHIFT    = 8'h59;
    localparam logic [7:0] C_SC_CTRL      = 8'h14;
    localparam logic [7:0] C_SC_CAPS      = 8'h58;

    // Non-extended special keys
    localparam logic [7:0] C_SC_ENTER     = 8'h5A;
    localparam logic [7:0] C_SC_BKSP      = 8'h66;
    localparam logic [7:0] C_SC_SPACE     = 8'h29;
    localparam logic [7:0] C_SC_TAB       = 8'h0D;
    localparam logic [7:0] C_SC_ESC       = 8'h76;

    // Extended (E0-prefixed) special keys
    localparam logic [7:0] C_SC_UP        = 8'h75;
    localparam logic [7:0] C_SC_DOWN      = 8'h72;
    localparam logic [7:0] C_SC_LEFT      = 8'h6B;
    localparam logic [7:0] C_SC_RIGHT     = 8'h74;
    localparam logic [7:0] C_SC_DEL       = 8'h71;
    localparam logic [7:0] C_SC_HOME      = 8'h6C;
    localparam logic [7:0] C_SC_END       = 8'h69;

    // Character codes produced for the special keys
    localparam logic [7:0] C_ASC_CR       = 8'h0D;
    localparam logic [7:0] C_ASC_BS       = 8'h08;
    localparam logic [7:0] C_ASC_SPACE    = 8'h20;
    localparam logic [7:0] C_ASC_TAB      = 8'h09;
    localparam logic [7:0] C_ASC_ESC      = 8'h1B;
    localparam logic [7:0] C_ASC_UP       = 8'h11;
    localparam logic [7:0] C_ASC_DOWN     = 8'h12;
    localparam logic [7:0] C_ASC_LEFT     = 8'h13;
    localparam logic [7:0] C_ASC_RIGHT    = 8'h14;
    localparam logic [7:0] C_ASC_DEL      = 8'h7F;
    localparam logic [7:0] C_ASC_HOME     = 8'h02;
    localparam logic [7:0] C_ASC_END      = 8'h03;

    // Register offsets (word index taken from address bits [3:2])
    localparam logic [1:0] C_REG_DATA     = 2'd0;
    localparam logic [1:0] C_REG_STATUS   = 2'd1;
    localparam logic [1:0] C_REG_CTRL     = 2'd2;
    localparam logic [1:0] C_REG_RSVD     = 2'd3;

    // Protocol bytes are dropped wherever they show up in the stream
    function automatic logic is_ignored_byte(input logic [7:0] b);
        return (b == C_SC_BAT_OK) || (b == C_SC_ACK) || (b == C_SC_ECHO) ||
               (b == C_SC_RESEND) || (b == C_SC_OVERRUN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_ascii_lut.sv
`default_nettype none
// ============================================================================
// Module   : ps2_ascii_lut
// Brief    : Combinational Set-2 make-code to ASCII translation for a US
//            layout, honouring Shift, Caps Lock and Ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_ascii_lut
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    input  logic       ctrl,
    output logic       valid,
    output logic [7:0] ascii
);

    logic [4:0] w_letter_idx;   // 1..26 for a..z, 0 when not a letter
    logic       w_sym_hit;
    logic [7:0] w_sym_plain;
    logic [7:0] w_sym_shift;

    // Letter keys map to their alphabet position
    always_comb begin
        w_letter_idx = 5'd0;
        case (code)
            8'h1C: w_letter_idx = 5'd1;
            8'h32: w_letter_idx = 5'd2;
            8'h21: w_letter_idx = 5'd3;
            8'h23: w_letter_idx = 5'd4;
            8'h24: w_letter_idx = 5'd5;
            8'h2B: w_letter_idx = 5'd6;
            8'h34: w_letter_idx = 5'd7;
            8'h33: w_letter_idx = 5'd8;
            8'h43: w_letter_idx = 5'd9;
            8'h3B: w_letter_idx = 5'd10;
            8'h42: w_letter_idx = 5'd11;
            8'h4B: w_letter_idx = 5'd12;
            8'h3A: w_letter_idx = 5'd13;
            8'h31: w_letter_idx = 5'd14;
            8'h44: w_letter_idx = 5'd15;
            8'h4D: w_letter_idx = 5'd16;
            8'h15: w_letter_idx = 5'd17;
            8'h2D: w_letter_idx = 5'd18;
            8'h1B: w_letter_idx = 5'd19;
            8'h2C: w_letter_idx = 5'd20;
            8'h3C: w_letter_idx = 5'd21;
            8'h2A: w_letter_idx = 5'd22;
            8'h1D: w_letter_idx = 5'd23;
            8'h22: w_letter_idx = 5'd24;
            8'h35: w_letter_idx = 5'd25;
            8'h1A: w_letter_idx = 5'd26;
            default: w_letter_idx = 5'd0;
        endcase
    end

    // Digit and punctuation keys: unshifted / shifted US characters
    always_comb begin
        {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b0, 8'h00, 8'h00};
        case (code)
            8'h16: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h31, 8'h21}; // 1 !
            8'h1E: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h32, 8'h40}; // 2 @
            8'h26: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h33, 8'h23}; // 3 #
            8'h25: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h34, 8'h24}; // 4 $
            8'h2E: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h35, 8'h25}; // 5 %
            8'h36: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h36, 8'h5E}; // 6 ^
            8'h3D: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h37, 8'h26}; // 7 &
            8'h3E: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h38, 8'h2A}; // 8 *
            8'h46: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h39, 8'h28}; // 9 (
            8'h45: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h30, 8'h29}; // 0 )
            8'h0E: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h60, 8'h7E}; // ` ~
            8'h4E: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h2D, 8'h5F}; // - _
            8'h55: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h3D, 8'h2B}; // = +
            8'h54: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h5B, 8'h7B}; // [ {
            8'h5B: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h5D, 8'h7D}; // ] }
            8'h5D: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h5C, 8'h7C}; // \ |
            8'h4C: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h3B, 8'h3A}; // ; :
            8'h52: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h27, 8'h22}; // ' "
            8'h41: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h2C, 8'h3C}; // , <
            8'h49: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h2E, 8'h3E}; // . >
            8'h4A: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b1, 8'h2F, 8'h3F}; // / ?
            default: {w_sym_hit, w_sym_plain, w_sym_shift} = {1'b0, 8'h00, 8'h00};
        endcase
    end

    // Final selection: extended keys, letters, symbols, then plain specials
    always_comb begin
        valid = 1'b0;
        ascii = 8'h00;
        if (ext) begin
            case (code)
                C_SC_UP:    {valid, ascii} = {1'b1, C_ASC_UP};
                C_SC_DOWN:  {valid, ascii} = {1'b1, C_ASC_DOWN};
                C_SC_LEFT:  {valid, ascii} = {1'b1, C_ASC_LEFT};
                C_SC_RIGHT: {valid, ascii} = {1'b1, C_ASC_RIGHT};
                C_SC_DEL:   {valid, ascii} = {1'b1, C_ASC_DEL};
                C_SC_HOME:  {valid, ascii} = {1'b1, C_ASC_HOME};
                C_SC_END:   {valid, ascii} = {1'b1, C_ASC_END};
                default:    {valid, ascii} = {1'b0, 8'h00};
            endcase
        end else if (w_letter_idx != 5'd0) begin
            valid = 1'b1;
            // Ctrl takes priority and yields the control code 0x01..0x1A
            if (ctrl) begin
                ascii = {3'b000, w_letter_idx};
            end else if (shift ^ caps) begin
                ascii = {3'b010, w_letter_idx};
            end else begin
                ascii = {3'b011, w_letter_idx};
            end
        end else if (w_sym_hit) begin
            valid = 1'b1;
            ascii = shift ? w_sym_shift : w_sym_plain;
        end else begin
            case (code)
                C_SC_ENTER: {valid, ascii} = {1'b1, C_ASC_CR};
                C_SC_BKSP:  {valid, ascii} = {1'b1, C_ASC_BS};
                C_SC_SPACE: {valid, ascii} = {1'b1, C_ASC_SPACE};
                C_SC_TAB:   {valid, ascii} = {1'b1, C_ASC_TAB};
                C_SC_ESC:   {valid, ascii} = {1'b1, C_ASC_ESC};
                default:    {valid, ascii} = {1'b0, 8'h00};
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_decoder
// Brief    : Turns raw PS/2 Set-2 scan-code bytes into ASCII characters,
//            tracks prefixes and modifier state, buffers characters in a FIFO
//            and exposes DATA/STATUS/CTRL registers on a Wishbone slave port.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        wb_rst_n_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        char_avail_o
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(FIFO_DEPTH);

    // Decoder state and modifiers
    dec_state_t       r_state;
    dec_state_t       w_state_nxt;
    logic             w_key_evt;
    logic             w_key_brk;
    logic             w_key_ext;
    logic             r_lshift;
    logic             r_rshift;
    logic             r_ctrl;
    logic             r_caps;
    logic             w_shift;

    // Character translation
    logic             w_lut_valid;
    logic [7:0]       w_lut_ascii;

    // FIFO
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_head;
    logic             w_push;
    logic             w_push_ok;
    logic             w_drop;
    logic             w_pop;
    logic             w_flush;

    // Bus
    logic             r_ack;
    logic             w_access;
    logic             w_ack_cycle;
    logic [1:0]       w_reg_sel;
    logic             w_ctrl_wr;
    logic             w_ovf_clr;
    logic [8:0]       w_count9;

    // Byte selects and undecoded address/data bits are intentionally ignored
    logic             w_unused;
    assign w_unused = ^{wb_sel_i, wb_dat_i[31:2], wb_adr_i[31:4], wb_adr_i[1:0]};

    // ------------------------------------------------------------------
    // Scan-code prefix FSM
    // ------------------------------------------------------------------

    // State register; a reset mid-sequence discards any pending prefix
    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus a one-cycle key event carrying make/break and E0 flags
    always_comb begin
        w_state_nxt = r_state;
        w_key_evt   = 1'b0;
        w_key_brk   = 1'b0;
        w_key_ext   = 1'b0;
        if (byte_valid_i && !is_ignored_byte(byte_i)) begin
            case (r_state)
                ST_IDLE: begin
                    if (byte_i == C_SC_E0) begin
                        w_state_nxt = ST_EXT;
                    end else if (byte_i == C_SC_F0) begin
                        w_state_nxt = ST_BRK;
                    end else begin
                        w_key_evt = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (byte_i == C_SC_F0) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        w_key_evt   = 1'b1;
                        w_key_ext   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_key_evt   = 1'b1;
                    w_key_brk   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_key_evt   = 1'b1;
                    w_key_brk   = 1'b1;
                    w_key_ext   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Modifier tracking: shifts/ctrl follow make/break, Caps toggles on make
    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_ctrl   <= 1'b0;
            r_caps   <= 1'b0;
        end else if (w_key_evt) begin
            if (!w_key_ext && (byte_i == C_SC_LSHIFT)) begin
                r_lshift <= !w_key_brk;
            end
            if (!w_key_ext && (byte_i == C_SC_RSHIFT)) begin
                r_rshift <= !w_key_brk;
            end
            // Left and right (E0-prefixed) Ctrl share one flag
            if (byte_i == C_SC_CTRL) begin
                r_ctrl <= !w_key_brk;
            end
            if (!w_key_ext && !w_key_brk && (byte_i == C_SC_CAPS)) begin
                r_caps <= !r_caps;
            end
        end
    end

    assign w_shift = r_lshift | r_rshift;

    ps2_ascii_lut u_lut (
        .code  (byte_i),
        .ext   (w_key_ext),
        .shift (w_shift),
        .caps  (r_caps),
        .ctrl  (r_ctrl),
        .valid (w_lut_valid),
        .ascii (w_lut_ascii)
    );

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    assign w_full    = (r_count == C_CNT_MAX);
    assign w_empty   = (r_count == '0);
    assign w_head    = r_mem[r_rd_ptr];

    // Only make codes with a mapping produce a character
    assign w_push    = w_key_evt && !w_key_brk && w_lut_valid;
    // A same-cycle pop frees the slot, so a full FIFO can still accept
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // Pointers and occupancy; a flush overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    // Storage array; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_push_ok && !w_flush) begin
            r_mem[r_wr_ptr] <= w_lut_ascii;
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle clear
    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign char_avail_o = !w_empty;

    // ------------------------------------------------------------------
    // Wishbone slave
    // ------------------------------------------------------------------
    assign w_access    = wb_cyc_i && wb_stb_i;
    assign w_reg_sel   = wb_adr_i[3:2];
    // Side effects happen on the edge that closes the acknowledged access
    assign w_ack_cycle = r_ack && w_access;
    assign w_pop       = w_ack_cycle && !wb_we_i && (w_reg_sel == C_REG_DATA) && !w_empty;
    assign w_ctrl_wr   = w_ack_cycle && wb_we_i && (w_reg_sel == C_REG_CTRL);
    assign w_ovf_clr   = w_ctrl_wr && wb_dat_i[0];
    assign w_flush     = w_ctrl_wr && wb_dat_i[1];
    assign w_count9    = 9'(r_count);

    // One ack pulse per access, inserting a single wait state
    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= !r_ack && w_access;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_err_o = 1'b0;

    // Read mux, driven only while the slave is addressed
    always_comb begin
        wb_dat_o = 32'h0;
        if (w_access) begin
            case (w_reg_sel)
                C_REG_DATA: begin
                    if (!w_empty) begin
                        wb_dat_o = {23'd0, 1'b1, w_head};
                    end
                end
                C_REG_STATUS: begin
                    wb_dat_o = {16'd0, r_caps, r_ctrl, w_shift, r_ovf,
                                w_full, w_empty, 1'b0, w_count9};
                end
                default: wb_dat_o = 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_scancode_decoder
// Brief    : Self-checking bench for ps2_scancode_decoder: directed scenarios
//            followed by randomized keystrokes against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  kb_byte;
    logic        kb_valid;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_err, char_avail;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_ext, m_brk, m_lsh, m_rsh, m_ctl, m_caps, m_ovf;
    logic [7:0] m_q[$];

    // Key tables written from the keyboard layout
    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] sym_sc [21]    = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                   8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                   8'h41, 8'h49, 8'h4A};
    logic [7:0] sym_lo [21]    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                   8'h30, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                                   8'h2C, 8'h2E, 8'h2F};
    logic [7:0] sym_hi [21]    = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28,
                                   8'h29, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                                   8'h3C, 8'h3E, 8'h3F};
    logic [7:0] spc_sc [5]     = '{8'h5A, 8'h66, 8'h29, 8'h0D, 8'h76};
    logic [7:0] spc_ch [5]     = '{8'h0D, 8'h08, 8'h20, 8'h09, 8'h1B};
    logic [7:0] ext_sc [7]     = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h71, 8'h6C, 8'h69};
    logic [7:0] ext_ch [7]     = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h7F, 8'h02, 8'h03};

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.FIFO_DEPTH(16), .CNT_W(5)) dut (
        .clk          (clk),
        .wb_rst_n_i   (rst_n),
        .byte_i       (kb_byte),
        .byte_valid_i (kb_valid),
        .wb_cyc_i     (wb_cyc),
        .wb_stb_i     (wb_stb),
        .wb_we_i      (wb_we),
        .wb_adr_i     (wb_adr),
        .wb_dat_i     (wb_dat_w),
        .wb_sel_i     (wb_sel),
        .wb_dat_o     (wb_dat_r),
        .wb_ack_o     (wb_ack),
        .wb_err_o     (wb_err),
        .char_avail_o (char_avail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ASCII for a completed make code, or -1 when the key produces nothing
    function automatic int model_char(input logic [7:0] code, input bit ext,
                                      input bit sh, input bit cp, input bit ct);
        if (ext) begin
            for (int i = 0; i < 7; i++) if (ext_sc[i] == code) return int'(ext_ch[i]);
            return -1;
        end
        for (int i = 0; i < 26; i++) begin
            if (letter_sc[i] == code) begin
                if (ct) return i + 1;
                return (sh ^ cp) ? ('h41 + i) : ('h61 + i);
            end
        end
        for (int i = 0; i < 21; i++)
            if (sym_sc[i] == code) return sh ? int'(sym_hi[i]) : int'(sym_lo[i]);
        for (int i = 0; i < 5; i++) if (spc_sc[i] == code) return int'(spc_ch[i]);
        return -1;
    endfunction

    function automatic void model_reset();
        {m_ext, m_brk, m_lsh, m_rsh, m_ctl, m_caps, m_ovf} = '0;
        m_q.delete();
    endfunction

    // Byte-level behaviour: prefixes accumulate until a key byte completes them
    function automatic void model_byte(input logic [7:0] b);
        int ch;
        if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00}) return;
        if (!m_ext && !m_brk && b == 8'hE0) begin m_ext = 1; return; end
        if (!m_brk && b == 8'hF0) begin m_brk = 1; return; end
        if (!m_ext && b == 8'h12) m_lsh = !m_brk;
        else if (!m_ext && b == 8'h59) m_rsh = !m_brk;
        else if (b == 8'h14) m_ctl = !m_brk;
        else if (!m_ext && b == 8'h58) begin
            if (!m_brk) m_caps = !m_caps;
        end else if (!m_brk) begin
            ch = model_char(b, m_ext, m_lsh | m_rsh, m_caps, m_ctl);
            if (ch >= 0) begin
                if (m_q.size() < 16) m_q.push_back(ch[7:0]);
                else m_ovf = 1;
            end
        end
        m_ext = 0;
        m_brk = 0;
    endfunction

    function automatic logic [31:0] model_status();
        int n = m_q.size();
        return {16'd0, m_caps, m_ctl, (m_lsh | m_rsh), m_ovf, (n == 16), (n == 0), 1'b0, 9'(n)};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        kb_byte  = b;
        kb_valid = 1'b1;
        @(negedge clk);
        kb_valid = 1'b0;
        kb_byte  = 8'h00;
        model_byte(b);
    endtask

    // Sends n bytes packed MSB-first in v
    task automatic send_bytes(input int n, input logic [63:0] v);
        for (int i = n - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
    endtask

    task automatic wb_access(input bit we, input logic [1:0] sel, input logic [31:0] wdata,
                             output logic [31:0] rdata);
        bit ok = 0;
        rdata = '0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = {28'd0, sel, 2'b00}; wb_dat_w = wdata;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge clk); #1;
            if (wb_ack) begin ok = 1; rdata = wb_dat_r; end
        end
        check("wb_ack_seen", {31'd0, ok}, 32'd1);
        if (ok) begin @(posedge clk); #1; end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (ok) check("wb_ack_single", {31'd0, wb_ack}, 32'd0);
    endtask

    task automatic read_const(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        logic [31:0] d;
        wb_access(1'b0, sel, 32'd0, d);
        if (sel == 2'd0 && m_q.size() != 0) void'(m_q.pop_front());
        check(tag, d, exp);
    endtask

    task automatic read_data_model();
        logic [31:0] d, exp;
        exp = (m_q.size() != 0) ? {23'd0, 1'b1, m_q[0]} : 32'd0;
        wb_access(1'b0, 2'd0, 32'd0, d);
        if (m_q.size() != 0) void'(m_q.pop_front());
        check("rand_data", d, exp);
    endtask

    task automatic read_status_model();
        logic [31:0] d;
        wb_access(1'b0, 2'd1, 32'd0, d);
        check("rand_status", d, model_status());
        check("rand_char_avail", {31'd0, char_avail}, {31'd0, (m_q.size() != 0)});
    endtask

    task automatic write_ctrl(input logic [31:0] v);
        logic [31:0] d;
        wb_access(1'b1, 2'd2, v, d);
        if (v[0]) m_ovf = 0;
        if (v[1]) m_q.delete();
    endtask

    task automatic send_random_key();
        logic [7:0] code;
        bit ext = 0;
        bit brk = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 5))
            0: code = letter_sc[$urandom_range(0, 25)];
            1: code = sym_sc[$urandom_range(0, 20)];
            2: code = spc_sc[$urandom_range(0, 4)];
            3: begin code = ext_sc[$urandom_range(0, 6)]; ext = 1; end
            4: case ($urandom_range(0, 4))
                   0: code = 8'h12;
                   1: code = 8'h59;
                   2: code = 8'h14;
                   3: begin code = 8'h14; ext = 1; end
                   default: code = 8'h58;
               endcase
            default: begin code = 8'($urandom_range(0, 255)); ext = $urandom_range(0, 1) == 1; end
        endcase
        if (ext) send_byte(8'hE0);
        if (brk) send_byte(8'hF0);
        send_byte(code);
    endtask

    initial begin
        logic [31:0] d;
        int r;
        rst_n = 1'b0; kb_byte = 8'h00; kb_valid = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = 4'hF;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        check("reset_ack", {31'd0, wb_ack}, 32'd0);
        check("reset_err", {31'd0, wb_err}, 32'd0);
        check("reset_avail", {31'd0, char_avail}, 32'd0);
        check("reset_dat_idle", wb_dat_r, 32'd0);
        read_const("reset_status", 2'd1, 32'h0000_0400);

        // Plain letter, break dropped; one cycle to char_avail
        send_bytes(3, 64'h1CF01C);
        check("avail_after_make", {31'd0, char_avail}, 32'd1);
        read_const("a_plain", 2'd0, 32'h161);
        read_const("empty_read", 2'd0, 32'h000);

        // Shift held then released
        send_bytes(7, 64'h121CF01CF0121C);
        read_const("A_shift", 2'd0, 32'h141);
        read_const("a_after_shift", 2'd0, 32'h161);

        // Caps affects letters only; then toggle caps back off
        send_bytes(5, 64'h58F0581C16);
        read_const("A_caps", 2'd0, 32'h141);
        read_const("digit_caps", 2'd0, 32'h131);
        send_bytes(3, 64'h58F058);

        // Extended keys, extended break ignored
        send_bytes(7, 64'hE075E0F075E071);
        read_const("ext_up", 2'd0, 32'h111);
        read_const("ext_del", 2'd0, 32'h17F);
        read_const("ext_empty", 2'd0, 32'h000);

        // Ctrl-letter and typematic repeat
        send_bytes(4, 64'h141CF014);
        send_bytes(2, 64'h1C1C);
        send_bytes(2, 64'hF01C);
        read_const("ctrl_a", 2'd0, 32'h101);
        read_const("repeat_1", 2'd0, 32'h161);
        read_const("repeat_2", 2'd0, 32'h161);

        // Overflow at 17 characters, then clear ovf and flush
        repeat (17) send_bytes(3, 64'h1CF01C);
        read_const("ovf_status", 2'd1, 32'h0000_1810);
        write_ctrl(32'd1);
        read_const("ovf_cleared", 2'd1, 32'h0000_0810);
        write_ctrl(32'd2);
        read_const("flushed", 2'd1, 32'h0000_0400);
        read_const("flushed_data", 2'd0, 32'h000);

        // Full FIFO: push on the same edge as a pop is accepted
        repeat (16) send_bytes(3, 64'h1CF01C);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0;
        @(posedge clk); #1;
        check("sim_ack", {31'd0, wb_ack}, 32'd1);
        d = wb_dat_r;
        @(negedge clk);
        kb_byte = 8'h32; kb_valid = 1'b1;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        kb_valid = 1'b0; kb_byte = 8'h00;
        void'(m_q.pop_front());
        model_byte(8'h32);
        check("sim_old_head", d, 32'h161);
        read_const("sim_status", 2'd1, 32'h0000_0810);
        while (m_q.size() > 1) read_data_model();
        read_const("sim_pushed_last", 2'd0, 32'h162);
        read_const("addr3_read", 2'd3, 32'h0);

        // Randomized keystrokes and bus activity
        for (int it = 0; it < 500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      send_random_key();
            else if (r < 78) read_data_model();
            else if (r < 90) read_status_model();
            else if (r < 93) write_ctrl(32'd1);
            else if (r < 95) write_ctrl(32'd2);
            else if (r < 97) send_byte(8'hAA);
            else             read_const("rand_addr3", 2'd3, 32'h0);
        end
        // Release modifiers so state is well defined, then drain
        send_bytes(2, 64'hF012); send_bytes(2, 64'hF059); send_bytes(2, 64'hF014);
        for (int i = 0; i < 20 && m_q.size() != 0; i++) read_data_model();
        read_data_model();
        read_status_model();

        // Reset after an E0 prefix discards the prefix and the FIFO
        send_bytes(3, 64'h1CF01C);
        send_byte(8'hE0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_avail", {31'd0, char_avail}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        send_byte(8'h75);
        read_const("post_reset_data", 2'd0, 32'h000);
        read_const("post_reset_status", 2'd1, 32'h0000_0400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
